// File: rtl/muldiv_pkg.sv
// Shared opcode and FSM encodings for the sequential multiply/divide engine.
package muldiv_pkg;

  // op[1] selects divide, op[0] selects unsigned
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negate.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiplier (shift-add) and divider (restoring),
// one iteration per cycle, with start/busy/done handshake.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               is_signed, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign is_signed = SIGNED_EN && !op_q[0];
  assign is_div    = op_q[1];

  // Magnitudes: MIN maps to 2^(WIDTH-1) as an unsigned value, no width loss
  muldiv_negate #(.W(WIDTH)) u_mag_a (
    .neg_i(is_signed & a_q[WIDTH-1]), .x_i(a_q), .y_o(a_mag));
  muldiv_negate #(.W(WIDTH)) u_mag_b (
    .neg_i(is_signed & b_q[WIDTH-1]), .x_i(b_q), .y_o(b_mag));

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg_i(sgn_a_q ^ sgn_b_q), .x_i(acc_q), .y_o(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_fix_quo (
    .neg_i(sgn_a_q ^ sgn_b_q), .x_i(acc_q[WIDTH-1:0]), .y_o(quo_fix));
  muldiv_negate #(.W(WIDTH)) u_fix_rem (
    .neg_i(sgn_a_q), .x_i(acc_q[2*WIDTH-1:WIDTH]), .y_o(rem_fix));

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; shift left, trial-subtract, restore on borrow
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        op_d    = op_e'(op);
        a_d     = a;
        b_d     = b;
        state_d = S_PREP;
      end
      S_PREP: begin
        sgn_a_d = is_signed & a_q[WIDTH-1];
        sgn_b_d = is_signed & b_q[WIDTH-1];
        a_d     = a_mag;
        b_d     = b_mag;
        acc_d   = is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        dz_d    = 1'b0;
        if (is_div && b_q == '0) begin
          dz_d    = 1'b1;
          state_d = S_FIX;
        end else begin
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!dz_q) begin
          if (is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE) | done_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: 32-bit instance plus an 8-bit instance.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  muldiv_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch on the 32-bit DUT; lat = edges after the start edge until done is seen.
  // A start pulse is re-driven at offset pulse_at (0 = none) to probe that it is ignored.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int pulse_at, output int l);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 32'h1234_5678; b = 32'h0000_0003; op = OP_MULTU;
    l = 0;
    while (!done && l < 200) begin
      @(negedge clk);
      l++;
      start = (pulse_at != 0 && l == pulse_at);
    end
    start = 1'b0;
    if (l >= 200) check("timeout_done", 64'(l), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz",   64'(div_zero), 64'(0));
    check("rst_hi",   64'(hi), 64'(0));
    check("rst_lo",   64'(lo), 64'(0));
    rst_n = 1'b1;

    // 1. signed multiply, latency
    run32(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, lat);
    check("mult_lat", 64'(lat), 64'd34);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    // 2. unsigned vs signed on all-ones
    run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run32(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    check("mult_m1_hilo", {hi, lo}, 64'h0000_0000_0000_0001);

    // 3. divides
    run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat);
    check("div_lat", 64'(lat), 64'd34);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run32(OP_DIVU, 32'd100, 32'd7, 0, lat);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    // 4. divide by zero keeps previous result
    run32(OP_DIV, 32'd5, 32'd0, 0, lat);
    check("dz_lat", 64'(lat), 64'd2);
    check("dz_flag", 64'(div_zero), 64'(1));
    check("dz_hilo", {hi, lo}, {32'd2, 32'd14});
    repeat (3) @(negedge clk);
    check("dz_hold", 64'(div_zero), 64'(1));
    run32(OP_MULTU, 32'd3, 32'd5, 0, lat);
    check("dz_clear", 64'(div_zero), 64'(0));
    check("mulu_small", {hi, lo}, 64'd15);

    // 5. MIN / -1 wraps; start pulse mid-run must not disturb
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5, lat);
    check("minm1_lat", 64'(lat), 64'd34);
    check("minm1_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    repeat (2) @(negedge clk);
    check("minm1_idle", 64'(busy), 64'(0));

    // 6. reset mid-RUN aborts, then 8-bit signed MIN*MIN
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("run_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("abort_no_done", 64'(lat), 64'd40);

    @(negedge clk);
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd10);
    check("w8_hilo", {48'd0, hi8, lo8}, 64'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
